// File: rtl/md_unit_param.sv
// Iterative radix-2 multiply/divide unit with architectural HI/LO registers.
// One shared shift-add / restoring shift-subtract datapath serves mult, multu, div and divu.
module md_unit_param #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  // IDLE: wait start | RUN: one radix-2 step per cycle | FIX: sign fix, load hi/lo | DONE: done pulse
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic               div_q, div_d;
  logic               negq_q, negq_d;
  logic               negr_q, negr_d;
  logic               bz_q, bz_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               dbz_q, dbz_d;

  logic               sgn_op, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum, rem_sh, div_diff;
  logic [2*WIDTH-1:0] mul_next, div_next, prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  always_comb begin
    sgn_op = ~op[0];
    a_neg  = sgn_op & a[WIDTH-1];
    b_neg  = sgn_op & b[WIDTH-1];
    a_mag  = a_neg ? (~a + 1'b1) : a;
    b_mag  = b_neg ? (~b + 1'b1) : b;

    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Remainder stays below the divisor, so the borrow bit alone decides restore vs keep.
    rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff = rem_sh - {1'b0, m_q};
    div_next = div_diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                               : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    prod_fix = negq_q ? (~acc_q + 1'b1) : acc_q;
    quot_fix = negq_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    rem_fix  = negr_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    m_d     = m_q;
    a_d     = a_q;
    div_d   = div_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    bz_d    = bz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dbz_d   = dbz_q;

    if ((state_q == S_IDLE || state_q == S_DONE) && hi_we) hi_d = wdata;
    if ((state_q == S_IDLE || state_q == S_DONE) && lo_we) lo_d = wdata;

    unique case (state_q)
      S_IDLE: begin
        if (start && !cancel) begin
          state_d = S_RUN;
          cnt_d   = '0;
          div_d   = op[1];
          a_d     = a;
          negq_d  = a_neg ^ b_neg;
          negr_d  = a_neg;
          bz_d    = op[1] && (b == '0);
          m_d     = op[1] ? b_mag : a_mag;
          acc_d   = {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
        end
      end
      S_RUN: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else begin
          acc_d = div_q ? div_next : mul_next;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
          dbz_d   = bz_q;
          if (!div_q) begin
            {hi_d, lo_d} = prod_fix;
          end else if (bz_q) begin
            hi_d = a_q;
            lo_d = '1;
          end else begin
            hi_d = rem_fix;
            lo_d = quot_fix;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      m_q     <= '0;
      a_q     <= '0;
      div_q   <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      bz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      m_q     <= m_d;
      a_q     <= a_d;
      div_q   <= div_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      bz_q    <= bz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q == S_RUN) || (state_q == S_FIX);
  assign done        = (state_q == S_DONE);
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_md_unit_param.sv
// Scoreboard bench for md_unit_param: a 32-bit instance for the main checks and an 8-bit
// instance for the narrow-width divide.
module tb_md_unit_param;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  logic clk = 1'b0;
  logic clrn = 1'b0;

  logic        start = 0, cancel = 0, hi_we = 0, lo_we = 0;
  logic [1:0]  op = 0;
  logic [31:0] a = 0, b = 0, wdata = 0;
  logic        busy, done, dbz;
  logic [31:0] hi, lo;

  logic        start8 = 0;
  logic [1:0]  op8 = 0;
  logic [7:0]  a8 = 0, b8 = 0;
  logic        busy8, done8, dbz8;
  logic [7:0]  hi8, lo8;

  int   n_tests = 0;
  int   n_fail = 0;
  exp_t sb[$];
  exp_t last;

  md_unit_param #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .clrn(clrn), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div_by_zero(dbz), .hi(hi), .lo(lo));

  md_unit_param #(.WIDTH(8), .CNT_W(4)) dut8 (
    .clk(clk), .clrn(clrn), .start(start8), .op(op8), .a(a8), .b(b8),
    .cancel(1'b0), .hi_we(1'b0), .lo_we(1'b0), .wdata(8'h00),
    .busy(busy8), .done(done8), .div_by_zero(dbz8), .hi(hi8), .lo(lo8));

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t        e;
    logic [63:0] p;
    int          sx, sy;
    e.dbz = 1'b0;
    sx = x;
    sy = y;
    case (o)
      2'b00: begin
        p = longint'(sx) * longint'(sy);
        e.hi = p[63:32];
        e.lo = p[31:0];
      end
      2'b01: begin
        p = {32'h0, x} * {32'h0, y};
        e.hi = p[63:32];
        e.lo = p[31:0];
      end
      default: begin
        if (y == 32'h0) begin
          e.hi = x;
          e.lo = 32'hFFFF_FFFF;
          e.dbz = 1'b1;
        end else if (o == 2'b11) begin
          e.lo = x / y;
          e.hi = x % y;
        end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          e.lo = 32'h8000_0000;
          e.hi = 32'h0;
        end else begin
          e.lo = sx / sy;
          e.hi = sx % sy;
        end
      end
    endcase
    return e;
  endfunction

  // mid_start: pulse a second start during RUN; mid_write: pulse mthi during RUN.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input bit mid_start, input bit mid_write);
    int   bcnt;
    bit   seen;
    exp_t e;
    bcnt = 0;
    seen = 0;
    @(negedge clk);
    start = 1; op = o; a = x; b = y;
    sb.push_back(model(o, x, y));
    @(posedge clk);
    #1 start = 0;
    for (int i = 1; i <= 60 && !seen; i++) begin
      @(negedge clk);
      if (mid_start && i == 10) begin start = 1; op = 2'b01; a = 32'h5; b = 32'h9; end
      if (mid_start && i == 11) start = 0;
      if (mid_write && i == 12) begin hi_we = 1; wdata = 32'h1234; end
      if (mid_write && i == 13) hi_we = 0;
      if (busy) bcnt++;
      if (done) begin
        seen = 1;
        chk({tag, "_latency"}, 64'(i), 64'd34);
        chk({tag, "_busy_cycles"}, 64'(bcnt), 64'd33);
        e = sb.pop_front();
        last = e;
        chk({tag, "_hi"}, 64'(hi), 64'(e.hi));
        chk({tag, "_lo"}, 64'(lo), 64'(e.lo));
        chk({tag, "_dbz"}, 64'(dbz), 64'(e.dbz));
      end
    end
    if (!seen) chk({tag, "_timeout"}, 64'd0, 64'd1);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    int          dcnt;
    bit          seen8;

    #12;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    chk("rst_dbz", 64'(dbz), 64'd0);
    @(negedge clk);
    clrn = 1;

    run_op("mult_neg", 2'b00, 32'hFFFF_FFFE, 32'd3, 0, 0);
    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 0, 0);
    run_op("divu_zero", 2'b11, 32'd7, 32'd0, 0, 0);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    run_op("div_zero_neg", 2'b10, 32'hFFFF_FF00, 32'd0, 0, 0);
    run_op("div_pos_neg", 2'b10, 32'd100, 32'hFFFF_FFF9, 0, 0);
    for (int k = 0; k < 6; k++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = (k % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
      run_op("rand", ro, ra, rb, 0, 0);
    end
    run_op("mid_start", 2'b00, 32'h1234_5678, 32'hFFFF_0001, 1, 0);
    run_op("busy_write", 2'b01, 32'hDEAD_BEEF, 32'h0000_0100, 0, 1);

    // Cancel at RUN cycle 5: no done, hi/lo keep the last result.
    @(negedge clk);
    start = 1; op = 2'b00; a = 32'd11; b = 32'd13;
    @(posedge clk);
    #1 start = 0;
    for (int i = 1; i <= 5; i++) @(negedge clk);
    cancel = 1;
    @(negedge clk);
    cancel = 0;
    chk("cancel_busy", 64'(busy), 64'd0);
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("cancel_no_done", 64'(dcnt), 64'd0);
    chk("cancel_hilo", {hi, lo}, {last.hi, last.lo});

    // mthi/mtlo in IDLE.
    @(negedge clk);
    hi_we = 1; wdata = 32'h1234;
    @(negedge clk);
    hi_we = 0;
    chk("mthi_idle", 64'(hi), 64'h1234);
    chk("mthi_lo_kept", 64'(lo), 64'(last.lo));
    lo_we = 1; wdata = 32'hCAFE_0001;
    @(negedge clk);
    lo_we = 0;
    chk("mtlo_idle", 64'(lo), 64'hCAFE_0001);

    // Divide by zero leaves dbz=1 so the asynchronous reset has something to clear.
    run_op("pre_reset_dbz", 2'b11, 32'd9, 32'd0, 0, 0);
    @(negedge clk);
    start = 1; op = 2'b00; a = 32'd3; b = 32'd4;
    @(posedge clk);
    #1 start = 0;
    for (int i = 0; i < 8; i++) @(negedge clk);
    #2 clrn = 0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_dbz", 64'(dbz), 64'd0);
    chk("arst_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    clrn = 1;

    // WIDTH=8 divu 200/7.
    seen8 = 0;
    @(negedge clk);
    start8 = 1; op8 = 2'b11; a8 = 8'd200; b8 = 8'd7;
    @(posedge clk);
    #1 start8 = 0;
    for (int i = 1; i <= 30 && !seen8; i++) begin
      @(negedge clk);
      if (done8) begin
        seen8 = 1;
        chk("w8_latency", 64'(i), 64'd10);
        chk("w8_lo", 64'(lo8), 64'd28);
        chk("w8_hi", 64'(hi8), 64'd4);
        chk("w8_dbz", 64'(dbz8), 64'd0);
      end
    end
    if (!seen8) chk("w8_timeout", 64'd0, 64'd1);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
